// File: rtl/complement_conv_nbit.sv
// Chunk-serial complement converter: pass, ones' complement, negate or magnitude, CHUNK bits per clock.
// Optional saturation of the most-negative magnitude is enabled by defining COMPLEMENT_CONV_SAT_EN.
module complement_conv_nbit #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             neg,
  output logic             ovf
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
  localparam logic [WIDTH-1:0] SAT_VAL  = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [1:0]       mode_q;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] acc;

  logic             accept;
  logic             carry_init;
  logic             invert;
  logic [CHUNK-1:0] slice_op;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] next_acc;
  logic             sat_hit;

  assign accept     = start && ((state == IDLE) || (state == DONE));
  assign carry_init = (mode == 2'b10) || ((mode == 2'b11) && a[WIDTH-1]);

  // Magnitude only inverts negative operands; neg holds the latched operand MSB.
  assign invert = (mode_q == 2'b01) || (mode_q == 2'b10) || ((mode_q == 2'b11) && neg);

  always_comb begin
    slice_op = a_q[int'(idx)*CHUNK +: CHUNK];
    if (invert) begin
      slice_op = ~slice_op;
    end
    {slice_cout, slice_sum} = {1'b0, slice_op} + {{CHUNK{1'b0}}, carry};
    next_acc = acc;
    next_acc[int'(idx)*CHUNK +: CHUNK] = slice_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      neg    <= 1'b0;
      carry  <= 1'b0;
      idx    <= '0;
      acc    <= '0;
      a_q    <= '0;
      mode_q <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            a_q    <= a;
            mode_q <= mode;
            neg    <= a[WIDTH-1];
            carry  <= carry_init;
            idx    <= '0;
            acc    <= '0;
            state  <= BUSY;
            busy   <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        BUSY: begin
          acc   <= next_acc;
          carry <= slice_cout;
          // The final carry-out is dropped: arithmetic wraps modulo 2^WIDTH.
          if (idx == LAST_IDX) begin
            idx    <= '0;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= sat_hit ? SAT_VAL : next_acc;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef COMPLEMENT_CONV_SAT_EN
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic min_q;
  logic ovf_q;

  assign sat_hit = (mode_q == 2'b11) && min_q;

  // ovf changes only together with result, at the end of a conversion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      min_q <= (a == MIN_VAL);
    end else if ((state == BUSY) && (idx == LAST_IDX)) begin
      ovf_q <= sat_hit;
    end
  end

  assign ovf = ovf_q;
`else
  assign sat_hit = 1'b0;
  assign ovf     = 1'b0;
`endif

endmodule

// File: tb/tb_complement_conv_nbit.sv
// Self-checking bench for complement_conv_nbit (WIDTH=8, CHUNK=4) with a result scoreboard.
// Expectations follow COMPLEMENT_CONV_SAT_EN when it is defined for the build.
module tb_complement_conv_nbit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic [7:0] a;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       neg;
  logic       ovf;

  int num_checks = 0;
  int num_fail   = 0;

  typedef struct {
    logic [7:0] result;
    logic       neg;
    logic       ovf;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] exp_result;
    logic       exp_neg;
    logic       exp_ovf;
  } vec_t;

  exp_t       sb_q[$];
  vec_t       vecs[12];
  logic [7:0] last_result;

  complement_conv_nbit #(.WIDTH(8), .CHUNK(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .mode   (mode),
    .a      (a),
    .busy   (busy),
    .done   (done),
    .result (result),
    .neg    (neg),
    .ovf    (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [1:0] m, input logic [7:0] v);
    exp_t e;
    e.neg = v[7];
    e.ovf = 1'b0;
    case (m)
      2'b00:   e.result = v;
      2'b01:   e.result = ~v;
      2'b10:   e.result = 8'(9'd256 - {1'b0, v});
      default: e.result = v[7] ? 8'(9'd256 - {1'b0, v}) : v;
    endcase
`ifdef COMPLEMENT_CONV_SAT_EN
    if (m == 2'b11 && v == 8'h80) begin
      e.result = 8'h7F;
      e.ovf    = 1'b1;
    end
`endif
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives one start pulse and returns at the falling edge after the accepting edge.
  task automatic applyStimulus(input logic [1:0] m, input logic [7:0] v, input exp_t e);
    @(negedge clk);
    mode  = m;
    a     = v;
    start = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output int cycles);
    cycles = -1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (done) begin
        cycles = n;
        break;
      end
    end
  endtask

  task automatic compareDone(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checkOutput({name, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    checkOutput({name, "_result"}, 32'(result), 32'(e.result));
    checkOutput({name, "_neg"}, 32'(neg), 32'(e.neg));
    checkOutput({name, "_ovf"}, 32'(ovf), 32'(e.ovf));
    checkOutput({name, "_busy_in_done"}, 32'(busy), 32'd0);
    last_result = e.result;
  endtask

  task automatic runOne(input string name, input logic [1:0] m, input logic [7:0] v, input exp_t e);
    int cycles;
    applyStimulus(m, v, e);
    checkOutput({name, "_busy"}, 32'(busy), 32'd1);
    checkOutput({name, "_held"}, 32'(result), 32'(last_result));
    waitDone(cycles);
    checkOutput({name, "_latency"}, 32'(cycles), 32'd2);
    compareDone(name);
  endtask

  initial begin
    int   cycles;
    int   pulses;
    exp_t e;
    logic [1:0] rm;
    logic [7:0] ra;

    vecs[0]  = '{2'b11, 8'hF3, 8'h0D, 1'b1, 1'b0};
    vecs[1]  = '{2'b10, 8'h01, 8'hFF, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 8'h5A, 8'hA5, 1'b0, 1'b0};
    vecs[3]  = '{2'b00, 8'h5A, 8'h5A, 1'b0, 1'b0};
`ifdef COMPLEMENT_CONV_SAT_EN
    vecs[4]  = '{2'b11, 8'h80, 8'h7F, 1'b1, 1'b1};
`else
    vecs[4]  = '{2'b11, 8'h80, 8'h80, 1'b1, 1'b0};
`endif
    vecs[5]  = '{2'b11, 8'h7F, 8'h7F, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[7]  = '{2'b10, 8'h80, 8'h80, 1'b1, 1'b0};
    vecs[8]  = '{2'b01, 8'h80, 8'h7F, 1'b1, 1'b0};
    vecs[9]  = '{2'b10, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[10] = '{2'b11, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{2'b00, 8'hC3, 8'hC3, 1'b1, 1'b0};

    rst   = 1'b1;
    start = 1'b0;
    mode  = 2'b00;
    a     = 8'h00;
    last_result = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", 32'({busy, done, neg, ovf, result}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      e.result = vecs[i].exp_result;
      e.neg    = vecs[i].exp_neg;
      e.ovf    = vecs[i].exp_ovf;
      runOne($sformatf("vec%0d", i), vecs[i].mode, vecs[i].a, e);
    end

    for (int i = 0; i < 16; i++) begin
      rm = 2'($urandom_range(0, 3));
      ra = 8'($urandom_range(0, 255));
      runOne($sformatf("rand%0d", i), rm, ra, model(rm, ra));
    end

    // start during BUSY must not disturb the running conversion
    e.result = 8'h0D; e.neg = 1'b1; e.ovf = 1'b0;
    applyStimulus(2'b11, 8'hF3, e);
    start = 1'b1;
    a     = 8'h10;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignore_no_early_done", 32'(done), 32'd0);
    waitDone(cycles);
    checkOutput("ignore_done_seen", 32'(cycles), 32'd1);
    compareDone("ignore");
    pulses = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checkOutput("ignore_single_done", 32'(pulses), 32'd0);

    // reset in the first BUSY cycle aborts without done
    e.result = 8'h0D; e.neg = 1'b1; e.ovf = 1'b0;
    applyStimulus(2'b11, 8'hF3, e);
    void'(sb_q.pop_back());
    rst = 1'b1;
    #1;
    checkOutput("abort_outputs", 32'({busy, done, neg, ovf, result}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_result = 8'h00;
    pulses = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    checkOutput("abort_no_done", 32'(pulses), 32'd0);
    e.result = 8'h05; e.neg = 1'b0; e.ovf = 1'b0;
    runOne("after_abort", 2'b11, 8'h05, e);

    // start held high: done on every third cycle, busy low only in DONE
    @(negedge clk);
    mode  = 2'b10;
    a     = 8'h33;
    start = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      checkOutput($sformatf("b2b_done_c%0d", i), 32'(done), 32'((i % 3) == 0));
      checkOutput($sformatf("b2b_busy_c%0d", i), 32'(busy), 32'((i % 3) != 0));
      if (i == 3) begin
        checkOutput("b2b_result1", 32'(result), 32'h0000_00CD);
        a = 8'h01;
      end else if (i == 6) begin
        checkOutput("b2b_result2", 32'(result), 32'h0000_00FF);
        a = 8'h80;
      end else if (i == 9) begin
        checkOutput("b2b_result3", 32'(result), 32'h0000_0080);
        start = 1'b0;
      end
    end
    @(negedge clk);
    checkOutput("b2b_idle", 32'({busy, done}), 32'd0);
    checkOutput("b2b_hold", 32'(result), 32'h0000_0080);

    checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
